sv32_tlb_reg: RTL

- Fully associative Sv32 TLB with a registered lookup path. It is the responder for the flush/lookup interface used by the TLB benches.
- It consumes flush requests (ASID and vaddr), refill updates from the PTW, and lookup requests.
- One cycle after a lookup it returns lu_hit_o, lu_content_o and lu_is_4M_o.
- It is instantiated twice by the MMU, once as the ITLB and once as the DTLB. Replacement uses a tree pseudo-LRU.

---
 rtl/sv32_tlb_reg_pkg.sv | 28 ++
 rtl/sv32_tlb_reg_plru_tree.sv | 50 +++++
 rtl/sv32_tlb_reg.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sv32_tlb_reg_pkg.sv
// Shared Sv32 TLB types: PTE layout, ASID width and the per-entry tag/content record.
package sv32_tlb_reg_pkg;

  localparam int unsigned ASID_WIDTH = 9;

  typedef struct packed {
    logic [21:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_sv32_t;

  typedef struct packed {
    logic                  valid;
    logic [ASID_WIDTH-1:0] asid;
    logic [9:0]            vpn1;
    logic [9:0]            vpn0;
    logic                  is_4M;
    pte_sv32_t             content;
  } tlb_entry_sv32_t;

endpackage

// File: rtl/sv32_tlb_reg_plru_tree.sv
// Tree pseudo-LRU over ENTRIES ways; two ordered touch ports, slot 1 is applied last.
module plru_tree #(
  parameter int unsigned ENTRIES = 4,
  localparam int unsigned IW = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [1:0]         touch_valid_i,
  input  logic [1:0][IW-1:0] touch_idx_i,
  output logic [IW-1:0]      victim_idx_o
);

  logic [ENTRIES-2:0] tree_q;
  logic [ENTRIES-2:0] tree_d;
  logic               node_bit;

  // Node (2^l - 1 + k) at level l covers index prefix k; set it to point away from the touched way.
  always_comb begin
    tree_d = tree_q;
    for (int unsigned t = 0; t < 2; t++) begin
      if (touch_valid_i[t]) begin
        for (int unsigned l = 0; l < IW; l++) begin
          for (int unsigned k = 0; k < (32'd1 << l); k++) begin
            if ((touch_idx_i[t] >> (IW - l)) == IW'(k))
              tree_d[(32'd1 << l) - 32'd1 + k] = ~touch_idx_i[t][IW - 1 - l];
          end
        end
      end
    end
  end

  always_comb begin
    victim_idx_o = '0;
    node_bit     = 1'b0;
    for (int unsigned l = 0; l < IW; l++) begin
      node_bit = 1'b0;
      for (int unsigned k = 0; k < (32'd1 << l); k++) begin
        if (victim_idx_o == IW'(k))
          node_bit = tree_q[(32'd1 << l) - 32'd1 + k];
      end
      victim_idx_o = (victim_idx_o << 1) | IW'(node_bit);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tree_q <= '0;
    else         tree_q <= tree_d;
  end

endmodule

// File: rtl/sv32_tlb_reg.sv
// Fully associative Sv32 TLB with one-cycle registered lookup, SFENCE flush and PTW refill.
module sv32_tlb_reg #(
  parameter int unsigned TLB_ENTRIES = 4,
  parameter int unsigned ASID_WIDTH  = sv32_tlb_reg_pkg::ASID_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [ASID_WIDTH-1:0] asid_to_be_flushed_i,
  input  logic [31:0]           vaddr_to_be_flushed_i,
  input  logic                  update_valid_i,
  input  logic [19:0]           update_vpn_i,
  input  logic [ASID_WIDTH-1:0] update_asid_i,
  input  logic                  update_is_4M_i,
  input  logic [31:0]           update_content_i,
  input  logic                  lu_access_i,
  input  logic [ASID_WIDTH-1:0] lu_asid_i,
  input  logic [31:0]           lu_vaddr_i,
  output logic                  lu_valid_o,
  output logic                  lu_hit_o,
  output logic [31:0]           lu_content_o,
  output logic                  lu_is_4M_o
);
  import sv32_tlb_reg_pkg::*;

  localparam int unsigned IW  = $clog2(TLB_ENTRIES);
  localparam int unsigned PAW = sv32_tlb_reg_pkg::ASID_WIDTH;

  tlb_entry_sv32_t tags_q [TLB_ENTRIES];

  logic [PAW-1:0]         lu_asid_x, upd_asid_x, fl_asid_x;
  logic                   fl_all_asid, fl_all_va;
  logic [TLB_ENTRIES-1:0] fl_inv;
  logic                   lu_any, upd_any, inv_any;
  logic [IW-1:0]          lu_idx, upd_idx, inv_idx, victim_idx, wr_idx;
  logic                   lu_touch;
  logic [1:0]             touch_valid;
  logic [1:0][IW-1:0]     touch_idx;
  tlb_entry_sv32_t        new_entry;
  logic                   unused_vaddr_lsbs;

  assign unused_vaddr_lsbs = ^{lu_vaddr_i[11:0], vaddr_to_be_flushed_i[11:0]};

  always_comb begin
    lu_asid_x  = '0;
    upd_asid_x = '0;
    fl_asid_x  = '0;
    lu_asid_x[ASID_WIDTH-1:0]  = lu_asid_i;
    upd_asid_x[ASID_WIDTH-1:0] = update_asid_i;
    fl_asid_x[ASID_WIDTH-1:0]  = asid_to_be_flushed_i;
  end

  assign fl_all_asid = (asid_to_be_flushed_i == '0);
  assign fl_all_va   = (vaddr_to_be_flushed_i[31:12] == '0);

  always_comb begin
    lu_any  = 1'b0;
    lu_idx  = '0;
    upd_any = 1'b0;
    upd_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    fl_inv  = '0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      logic lu_m, upd_m, va_m;
      lu_m  = tags_q[i].valid
           && ((tags_q[i].asid == lu_asid_x) || tags_q[i].content.g)
           && (tags_q[i].vpn1 == lu_vaddr_i[31:22])
           && (tags_q[i].is_4M || (tags_q[i].vpn0 == lu_vaddr_i[21:12]));
      upd_m = tags_q[i].valid
           && (tags_q[i].asid == upd_asid_x)
           && (tags_q[i].vpn1 == update_vpn_i[19:10])
           && (tags_q[i].is_4M == update_is_4M_i)
           && (update_is_4M_i || (tags_q[i].vpn0 == update_vpn_i[9:0]));
      va_m  = (tags_q[i].vpn1 == vaddr_to_be_flushed_i[31:22])
           && (tags_q[i].is_4M || (tags_q[i].vpn0 == vaddr_to_be_flushed_i[21:12]));
      // ASID-qualified flushes spare global mappings; ASID 0 flushes reach everything.
      if (fl_all_asid) fl_inv[i] = fl_all_va || va_m;
      else             fl_inv[i] = !tags_q[i].content.g && (tags_q[i].asid == fl_asid_x)
                                   && (fl_all_va || va_m);
      if (lu_m && !lu_any) begin
        lu_any = 1'b1;
        lu_idx = IW'(i);
      end
      if (upd_m && !upd_any) begin
        upd_any = 1'b1;
        upd_idx = IW'(i);
      end
      if (!tags_q[i].valid && !inv_any) begin
        inv_any = 1'b1;
        inv_idx = IW'(i);
      end
    end
  end

  always_comb begin
    if (upd_any)      wr_idx = upd_idx;
    else if (inv_any) wr_idx = inv_idx;
    else              wr_idx = victim_idx;
  end

  always_comb begin
    new_entry.valid   = 1'b1;
    new_entry.asid    = upd_asid_x;
    new_entry.vpn1    = update_vpn_i[19:10];
    new_entry.vpn0    = update_vpn_i[9:0];
    new_entry.is_4M   = update_is_4M_i;
    new_entry.content = pte_sv32_t'(update_content_i);
  end

  assign lu_touch    = lu_access_i && lu_any && !flush_i;
  assign touch_valid = {update_valid_i && !flush_i, lu_touch};
  assign touch_idx   = {wr_idx, lu_idx};

  plru_tree #(
    .ENTRIES (TLB_ENTRIES)
  ) u_plru (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .touch_valid_i (touch_valid),
    .touch_idx_i   (touch_idx),
    .victim_idx_o  (victim_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < TLB_ENTRIES; i++) tags_q[i] <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < TLB_ENTRIES; i++)
        if (fl_inv[i]) tags_q[i].valid <= 1'b0;
    end else if (update_valid_i) begin
      tags_q[wr_idx] <= new_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lu_valid_o   <= 1'b0;
      lu_hit_o     <= 1'b0;
      lu_content_o <= '0;
      lu_is_4M_o   <= 1'b0;
    end else begin
      lu_valid_o <= lu_access_i;
      if (lu_touch) begin
        lu_hit_o     <= 1'b1;
        lu_content_o <= tags_q[lu_idx].content;
        lu_is_4M_o   <= tags_q[lu_idx].is_4M;
      end else begin
        lu_hit_o     <= 1'b0;
        lu_content_o <= '0;
        lu_is_4M_o   <= 1'b0;
      end
    end
  end

endmodule
